mem_bus_arb: RTL
================

Name: mem_bus_arb

Overview:
Two-port arbiter that shares the hart's single external line bus between the instruction cache (read-only) and the data cache (read and write-through write).
- Serialises whole-line transactions with a registered grant FSM.
- Uses round-robin on contention.
- Returns completion pulses to the owning cache.
- Sits between the hart's caches and the system memory interface.

Parameters:
ADDR_W, 64, address width in bits.
LINE_W, 1024, cache line width in bits; the line is 128 bytes, so the low 7 address bits are the line offset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
clr_n  in  1  asynchronous active-low reset.
i_addr  in  ADDR_W  icache request address.
i_rd  in  1  icache line read request; level, held until i_dv.
i_data  out  LINE_W  line returned to icache.
i_dv  out  1  icache completion pulse.
d_addr  in  ADDR_W  dcache request address.
d_rd  in  1  dcache line read request; level, held until d_dv.
d_wr  in  1  dcache line write request; level, held until d_dv.
d_data_wr  in  LINE_W  line to write.
d_data_rd  out  LINE_W  line returned to dcache.
d_dv  out  1  dcache completion pulse (read data valid or write done).
m_addr  out  ADDR_W  memory line address, low 7 bits zero.
m_rd  out  1  memory read strobe.
m_wr  out  1  memory write strobe.
m_data_out  out  LINE_W  write data to memory.
m_data_in  in  LINE_W  read data from memory.
m_dv  in  1  memory completion; one-cycle pulse.

Behaviour:
- Reset (async, clr_n low):
  - State IDLE; rr=0.
  - m_rd=0, m_wr=0, m_addr=0, m_data_out=0.
  - i_dv=0, d_dv=0.
  - Any in-flight memory transaction is abandoned; the memory side must tolerate strobe drop.
- States: IDLE, BUSY_I, BUSY_DR, BUSY_DW, DONE.
- IDLE, requests sampled at the clock edge:
  - No request: stay in IDLE.
  - Only i_rd: go to BUSY_I.
  - Only d_rd or d_wr: go to BUSY_DR or BUSY_DW. If d_rd and d_wr are both high, d_wr wins (BUSY_DW).
  - i_rd together with d_rd/d_wr: grant the requester not served last. rr=0 means icache was last served (or reset), so dcache wins; rr=1 means icache wins.
- On grant, same edge:
  - m_addr <= {addr[ADDR_W-1:7], 7'b0} of the winner.
  - For BUSY_DW, m_data_out <= d_data_wr.
  - m_rd <= 1 (BUSY_I/BUSY_DR) or m_wr <= 1 (BUSY_DW).
- Latency: a request high at edge N gives a strobe high from cycle N+1.
- BUSY_*:
  - m_addr, m_data_out and the strobe are held constant.
  - Requester inputs are ignored, including a dropped request: the transaction still completes and the dv pulse is still produced.
- Completion (combinational, no added latency):
  - i_dv = m_dv && state==BUSY_I.
  - d_dv = m_dv && (state==BUSY_DR || state==BUSY_DW).
  - i_data = m_data_in and d_data_rd = m_data_in at all times; they are meaningful only while the matching dv is high.
- At the m_dv edge:
  - Strobes go low (registered).
  - rr <= 0 if BUSY_I completed, rr <= 1 if a dcache transaction completed.
  - Go to DONE.
- DONE:
  - Lasts exactly one cycle with strobes low and requests ignored, so a requester can drop its request after dv without a stale re-grant.
  - Then go to IDLE.
- m_dv in IDLE or DONE is ignored: no dv output and no state change.
- Throughput: back-to-back transactions cost strobe cycles + memory latency + 1 DONE cycle + 1 IDLE grant cycle.
- At most one of m_rd/m_wr is high at any time, and never outside BUSY_*.

Test Plan:
- Reset, then i_rd=1, i_addr=0x1000_0045; memory asserts m_dv 3 cycles after m_rd with m_data_in=pattern A.
  - Required: m_rd high the cycle after the request, m_addr=0x1000_0000.
  - Required: i_dv pulses 1 cycle with i_data=A; d_dv stays 0.
- Simultaneous i_rd and d_rd right after reset.
  - Required: dcache granted first (rr=0).
  - Required: after d_dv, DONE, then IDLE, the icache is granted with i_rd still held, i.e. m_rd rises again 3 cycles after d_dv.
- d_wr=1, d_addr=0x80, d_data_wr=pattern B.
  - Required: m_wr=1, m_rd=0, m_addr=0x80, m_data_out=B, all held until m_dv.
  - Required: d_dv pulses with m_dv; m_wr low the next cycle.
- d_rd and d_wr both high with i_rd low → BUSY_DW taken.
  - Required: m_wr=1 and m_rd=0.
- Stray m_dv in IDLE → no i_dv/d_dv pulse and state stays IDLE.
- clr_n low while m_rd is high in BUSY_I.
  - Required: m_rd=0 immediately, without waiting for a clock.
  - Required: after release, a fresh d_rd is granted normally and the earlier icache m_dv produces no i_dv.

Source files
------------

// File: rtl/mem_bus_arb.sv
// Line-bus arbiter: serialises whole-line icache reads and dcache reads/writes
// onto one memory port, round-robin on contention, with a one-cycle DONE gap.
module mem_bus_arb #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 1024
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_data_wr,
    output logic [LINE_W-1:0] d_data_rd,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [LINE_W-1:0] m_data_out,
    input  logic [LINE_W-1:0] m_data_in,
    input  logic              m_dv
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BUSY_I  = 3'd1;
    localparam logic [2:0] BUSY_DR = 3'd2;
    localparam logic [2:0] BUSY_DW = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(7'h7f);

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a & ~OFF_MASK;
    endfunction

    logic [2:0] state;
    logic       rr;      // 1: icache has priority on the next contention
    logic       d_req;
    logic       d_wins;

    assign d_req  = d_rd | d_wr;
    assign d_wins = d_req && (!i_rd || !rr);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            rr         <= 1'b0;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        m_addr <= line_addr(d_addr);
                        // a simultaneous read and write from the dcache resolves to the write
                        if (d_wr) begin
                            state      <= BUSY_DW;
                            m_wr       <= 1'b1;
                            m_data_out <= d_data_wr;
                        end else begin
                            state <= BUSY_DR;
                            m_rd  <= 1'b1;
                        end
                    end else if (i_rd) begin
                        state  <= BUSY_I;
                        m_addr <= line_addr(i_addr);
                        m_rd   <= 1'b1;
                    end
                end
                BUSY_I, BUSY_DR, BUSY_DW: begin
                    if (m_dv) begin
                        m_rd  <= 1'b0;
                        m_wr  <= 1'b0;
                        rr    <= (state != BUSY_I);
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_dv      = m_dv && (state == BUSY_I);
    assign d_dv      = m_dv && ((state == BUSY_DR) || (state == BUSY_DW));
    assign i_data    = m_data_in;
    assign d_data_rd = m_data_in;

endmodule
